// File: rtl/debug_axi_master.sv
// Single-outstanding AXI4 master with a request FIFO; one 32-bit beat per transaction.
// Optional transaction timeout: define DEBUG_AXI_MASTER_TIMEOUT_EN.
module debug_axi_master #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic        rsp_rd,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        err_flag,
  output logic [3:0]  M_AWID,
  output logic [31:0] M_AWADDR,
  output logic        M_AWVALID,
  input  logic        M_AWREADY,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  output logic        M_WVALID,
  input  logic        M_WREADY,
  input  logic [3:0]  M_BID,
  input  logic [1:0]  M_BRESP,
  input  logic        M_BVALID,
  output logic        M_BREADY,
  output logic [3:0]  M_ARID,
  output logic [31:0] M_ARADDR,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [3:0]  M_RID,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RVALID,
  output logic        M_RREADY
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("debug_axi_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 2");
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t           state;
  req_t             mem [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       id_cnt;
  logic             aw_done, w_done;
  logic             full, empty, push, pop;
  logic             aw_fin, w_fin, b_hs, r_hs, b_err, r_err;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = req_valid & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign head      = mem[rd_ptr];
  assign req_ready = ~full;
  assign busy      = (state != IDLE) | ~empty;

  assign aw_fin = aw_done | (M_AWVALID & M_AWREADY);
  assign w_fin  = w_done  | (M_WVALID  & M_WREADY);
  assign b_hs   = (state == WRESP) & M_BVALID;
  assign r_hs   = (state == RDATA) & M_RVALID;
  assign b_err  = (M_BRESP != 2'b00) | (M_BID != M_AWID);
  assign r_err  = (M_RRESP != 2'b00) | (M_RID != M_ARID);

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef DEBUG_AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Transaction sequencer; every AXI and response output is a flop here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      id_cnt    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_flag  <= 1'b0;
      M_AWID    <= '0;
      M_AWADDR  <= '0;
      M_AWVALID <= 1'b0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARID    <= '0;
      M_ARADDR  <= '0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
`ifdef DEBUG_AXI_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            id_cnt <= id_cnt + 4'd1;
            if (head.we) begin
              M_AWID   <= id_cnt;
              M_AWADDR <= head.addr;
              M_WDATA  <= head.wdata;
              M_WSTRB  <= head.wstrb;
              aw_done  <= 1'b0;
              w_done   <= 1'b0;
              state    <= WADDR;
            end else begin
              M_ARID   <= id_cnt;
              M_ARADDR <= head.addr;
              state    <= RADDR;
            end
          end
        end
        WADDR: begin
          // AW and W rise together on the first cycle, then retire independently.
          if (M_AWVALID && M_AWREADY) begin
            M_AWVALID <= 1'b0;
            aw_done   <= 1'b1;
          end else if (!aw_done) begin
            M_AWVALID <= 1'b1;
          end
          if (M_WVALID && M_WREADY) begin
            M_WVALID <= 1'b0;
            w_done   <= 1'b1;
          end else if (!w_done) begin
            M_WVALID <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            M_BREADY <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (b_hs) begin
            M_BREADY  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rd    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= b_err;
            err_flag  <= err_flag | b_err;
            state     <= IDLE;
          end
        end
        RADDR: begin
          if (M_ARVALID && M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= RDATA;
          end else begin
            M_ARVALID <= 1'b1;
          end
        end
        RDATA: begin
          if (r_hs) begin
            M_RREADY  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rd    <= 1'b1;
            rsp_rdata <= M_RDATA;
            rsp_err   <= r_err;
            err_flag  <= err_flag | r_err;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef DEBUG_AXI_MASTER_TIMEOUT_EN
      // Abort a stuck transaction; overrides the case above in the same cycle.
      if (state == IDLE) tmo_cnt <= '0;
      else               tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state != IDLE && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1) && !b_hs && !r_hs) begin
        M_AWVALID <= 1'b0;
        M_WVALID  <= 1'b0;
        M_BREADY  <= 1'b0;
        M_ARVALID <= 1'b0;
        M_RREADY  <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rd    <= (state == RADDR) || (state == RDATA);
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        err_flag  <= 1'b1;
        state     <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_debug_axi_master.sv
// Directed bench for debug_axi_master with a delay-programmable AXI slave model.
module tb_debug_axi_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_rd, rsp_err, busy, err_flag;
  logic [31:0] rsp_rdata;
  logic [3:0]  M_AWID, M_WSTRB, M_ARID;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
  logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic        M_AWREADY = 1'b0, M_WREADY = 1'b0, M_ARREADY = 1'b0;
  logic        M_BVALID = 1'b0, M_RVALID = 1'b0;
  logic [3:0]  M_BID = '0, M_RID = '0;
  logic [1:0]  M_BRESP = '0, M_RRESP = '0;
  logic [31:0] M_RDATA = '0;

  debug_axi_master #(.FIFO_DEPTH(4), .TIMEOUT_CYC(1024)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .err_flag(err_flag),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Slave configuration, written by the stimulus.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
  logic [3:0]  bid_xor = '0, rid_xor = '0;
  logic [31:0] rdata_xor = '0;

  // Slave observations.
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, w_only = 0;
  logic [3:0]  awid_l = '0, arid_l = '0;
  logic [31:0] araddr_l = '0;
  logic [3:0]  id_q[$];
  logic        rsp_rd_q[$];
  logic        rsp_err_q[$];
  logic [31:0] rsp_rdata_q[$];

  // Request bookkeeping.
  int n_acc = 0;
  int stall_at = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model: readies and responses driven on the falling edge.
  always @(negedge CLK) begin
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_ARREADY = 1'b0;
    M_BVALID  = 1'b0; M_RVALID = 1'b0;
    if (RST) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (M_AWVALID) begin
        if (aw_cnt == aw_dly) begin
          M_AWREADY = 1'b1; aw_cnt = 0; awid_l = M_AWID; id_q.push_back(M_AWID); aw_hs++;
        end else aw_cnt++;
      end else aw_cnt = 0;
      if (M_WVALID) begin
        if (w_cnt == w_dly) begin M_WREADY = 1'b1; w_cnt = 0; w_hs++; end
        else w_cnt++;
      end else w_cnt = 0;
      if (!M_AWVALID && M_WVALID) w_only++;
      if (M_BREADY) begin
        if (b_cnt == b_dly) begin
          M_BVALID = 1'b1; M_BID = awid_l ^ bid_xor; M_BRESP = bresp_cfg; b_cnt = 0; b_hs++;
        end else b_cnt++;
      end else b_cnt = 0;
      if (M_ARVALID) begin
        if (ar_cnt == ar_dly) begin
          M_ARREADY = 1'b1; ar_cnt = 0; arid_l = M_ARID; araddr_l = M_ARADDR; id_q.push_back(M_ARID);
        end else ar_cnt++;
      end else ar_cnt = 0;
      if (M_RREADY) begin
        if (r_cnt == r_dly) begin
          M_RVALID = 1'b1; M_RID = arid_l ^ rid_xor; M_RDATA = araddr_l ^ rdata_xor;
          M_RRESP = rresp_cfg; r_cnt = 0;
        end else r_cnt++;
      end else r_cnt = 0;
      if (rsp_valid) begin
        rsp_rd_q.push_back(rsp_rd); rsp_err_q.push_back(rsp_err); rsp_rdata_q.push_back(rsp_rdata);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    if (!req_ready && stall_at < 0) stall_at = n_acc;
    while (!req_ready && t < 1000) begin @(negedge CLK); t++; end
    if (t >= 1000) check("req_accept_timeout", 32'(t), 32'd0);
    @(negedge CLK);
    n_acc++;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int t = 0;
    while (rsp_rd_q.size() < n && t < 2000) begin @(negedge CLK); t++; end
    check(tag, 32'(rsp_rd_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic set_dly(input int d);
    aw_dly = d; w_dly = d; b_dly = d; ar_dly = d; r_dly = d;
  endtask

  initial begin
    int ib, rb, t, awh0, wh0, bh0, wo0;
    logic [31:0] a;
    do_reset();

    // Reset state
    check("rst_ctrl", {rsp_valid, rsp_err, busy, err_flag, M_AWVALID, M_WVALID,
                       M_BREADY, M_ARVALID, M_RREADY}, 32'd0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rdata", rsp_rdata, 0);

    // Single write: AW/W rise together two cycles after acceptance
    set_dly(1);
    ib = id_q.size(); rb = rsp_rd_q.size();
    send(1'b1, 32'h6000_0000, 32'h41, 4'hF);
    check("wr_lat0", {M_AWVALID, M_WVALID}, 0);
    @(negedge CLK);
    check("wr_lat1", {M_AWVALID, M_WVALID}, 0);
    @(negedge CLK);
    check("wr_lat2", {M_AWVALID, M_WVALID}, 2'b11);
    check("wr_awaddr", M_AWADDR, 32'h6000_0000);
    check("wr_wdata", M_WDATA, 32'h41);
    check("wr_wstrb", M_WSTRB, 4'hF);
    wait_rsp("wr_rsp_cnt", rb + 1);
    repeat (5) @(negedge CLK);
    check("wr_one_rsp", 32'(rsp_rd_q.size()), 32'(rb + 1));
    check("wr_rsp_rd", rsp_rd_q[rb], 0);
    check("wr_rsp_err", rsp_err_q[rb], 0);
    check("wr_rsp_rdata", rsp_rdata_q[rb], 0);
    check("wr_awid", id_q[ib], 0);
    check("wr_idle_busy", {busy, M_BREADY, err_flag}, 0);

    // Single read
    rdata_xor = 32'hBEAD_BEEF;
    ib = id_q.size(); rb = rsp_rd_q.size();
    send(1'b0, 32'h6000_0000, 32'h0, 4'h0);
    wait_rsp("rd_rsp_cnt", rb + 1);
    check("rd_araddr", araddr_l, 32'h6000_0000);
    check("rd_arid", id_q[ib], 1);
    check("rd_rsp_rd", rsp_rd_q[rb], 1);
    check("rd_rsp_rdata", rsp_rdata_q[rb], 32'hDEAD_BEEF);
    check("rd_rsp_err", rsp_err_q[rb], 0);

    // Bad BRESP, then BID mismatch, then a clean read: err_flag stays set
    rb = rsp_rd_q.size();
    bresp_cfg = 2'b10;
    send(1'b1, 32'h6000_0004, 32'h1, 4'h1);
    wait_rsp("bresp_rsp_cnt", rb + 1);
    check("bresp_err", rsp_err_q[rb], 1);
    @(negedge CLK);
    check("bresp_flag", err_flag, 1);
    bresp_cfg = 2'b00; bid_xor = 4'h3;
    send(1'b1, 32'h6000_0008, 32'h2, 4'h3);
    wait_rsp("bid_rsp_cnt", rb + 2);
    check("bid_err", rsp_err_q[rb + 1], 1);
    bid_xor = 4'h0;
    send(1'b0, 32'h6000_0000, 32'h0, 4'h0);
    wait_rsp("clean_rsp_cnt", rb + 3);
    check("clean_err", rsp_err_q[rb + 2], 0);
    repeat (3) @(negedge CLK);
    check("flag_sticky", err_flag, 1);
    do_reset();
    check("flag_cleared", err_flag, 0);

    // AWREADY three cycles ahead of WREADY
    aw_dly = 1; w_dly = 4; b_dly = 1;
    rb = rsp_rd_q.size(); awh0 = aw_hs; wh0 = w_hs; bh0 = b_hs; wo0 = w_only;
    send(1'b1, 32'h6000_0010, 32'h55AA_55AA, 4'hC);
    wait_rsp("skew_rsp_cnt", rb + 1);
    repeat (5) @(negedge CLK);
    check("skew_w_held", 32'(w_only - wo0), 3);
    check("skew_aw_hs", 32'(aw_hs - awh0), 1);
    check("skew_w_hs", 32'(w_hs - wh0), 1);
    check("skew_b_hs", 32'(b_hs - bh0), 1);
    check("skew_one_rsp", 32'(rsp_rd_q.size()), 32'(rb + 1));
    check("skew_bready_low", M_BREADY, 0);

    // Burst of 6 against a slow slave, fresh IDs
    do_reset();
    set_dly(8); rdata_xor = 32'h1234_5678;
    ib = id_q.size(); rb = rsp_rd_q.size(); n_acc = 0; stall_at = -1;
    for (int i = 0; i < 6; i++) send(i[0] ? 1'b0 : 1'b1, 32'h6000_0000 + 32'(4 * i), 32'(i), 4'hF);
    check("burst_stall_at", 32'(stall_at), 5);
    wait_rsp("burst_rsp_cnt", rb + 6);
    for (int i = 0; i < 6; i++) begin
      a = 32'h6000_0000 + 32'(4 * i);
      check($sformatf("burst_id%0d", i), id_q[ib + i], 32'(i));
      check($sformatf("burst_rd%0d", i), rsp_rd_q[rb + i], 32'(i % 2));
      check($sformatf("burst_rdata%0d", i), rsp_rdata_q[rb + i], i[0] ? (a ^ 32'h1234_5678) : 32'h0);
      check($sformatf("burst_err%0d", i), rsp_err_q[rb + i], 0);
    end

    // 17 writes: ID wraps 15 -> 0
    do_reset();
    set_dly(0);
    ib = id_q.size(); rb = rsp_rd_q.size();
    for (int i = 0; i < 17; i++) send(1'b1, 32'h6000_0000, 32'(i), 4'hF);
    wait_rsp("wrap_rsp_cnt", rb + 17);
    check("wrap_id15", id_q[ib + 15], 15);
    check("wrap_id16", id_q[ib + 16], 0);
    t = 0;
    for (int i = 0; i < 17; i++) if (id_q[ib + i] != 4'(i)) t++;
    check("wrap_id_all_bad", 32'(t), 0);

    // Reset while waiting in WRESP: transaction abandoned silently
    b_dly = 50;
    rb = rsp_rd_q.size();
    send(1'b1, 32'h6000_0020, 32'hCAFE_F00D, 4'hF);
    t = 0;
    while (!M_BREADY && t < 200) begin @(negedge CLK); t++; end
    check("wresp_reached", M_BREADY, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_ctrl", {rsp_valid, rsp_rd, rsp_err, busy, err_flag, M_AWVALID, M_WVALID,
                          M_BREADY, M_ARVALID, M_RREADY}, 32'd0);
    check("midrst_awaddr", M_AWADDR, 0);
    check("midrst_wdata", M_WDATA, 0);
    check("midrst_req_ready", req_ready, 1);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("midrst_no_rsp", 32'(rsp_rd_q.size()), 32'(rb));
    b_dly = 1;
    ib = id_q.size();
    send(1'b1, 32'h6000_0024, 32'h7, 4'hF);
    wait_rsp("post_rst_rsp_cnt", rb + 1);
    check("post_rst_id", id_q[ib], 0);
    check("post_rst_err", rsp_err_q[rb], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_axi_master.md
Name: debug_axi_master

Overview:
- Testbench-side AXI4 (single-beat, 32-bit) master that sits directly upstream of the debug peripheral at 0x6000_0000.
- Accepts simple read/write requests from a bench or core-side LSU model via valid/ready, buffers them in a small FIFO, and issues one AXI transaction at a time.
- Issues AW and W together, because the debug slave raises AWREADY/WREADY only when both valids are seen.
- Returns a response pulse per request and keeps a sticky protocol-error flag.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYC, 1024, cycles before a pending transaction is declared dead (used only with the optional feature).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request FIFO can accept
- req_we  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rd  out  1  response belongs to a read
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  this transaction had bad RESP or ID mismatch
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_flag  out  1  sticky OR of all rsp_err
- M_AWID/M_AWADDR/M_AWVALID  out  4/32/1;  M_AWREADY  in  1
- M_WDATA/M_WSTRB/M_WVALID  out  32/4/1;  M_WREADY  in  1
- M_BID/M_BRESP/M_BVALID  in  4/2/1;  M_BREADY  out  1
- M_ARID/M_ARADDR/M_ARVALID  out  4/32/1;  M_ARREADY  in  1
- M_RID/M_RDATA/M_RRESP/M_RVALID  in  4/32/2/1;  M_RREADY  out  1

Behaviour:
- Reset: all outputs 0 except req_ready=1. FIFO empty, FSM to IDLE, id_cnt=0, err_flag=0. A reset mid-transaction abandons it with no response.
- Clock and reset: one clock CLK; RST is synchronous and active-high.
- FIFO:
  - req_ready = ~full. Push on req_valid & req_ready.
  - No push while full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are legal when not full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA (one-hot or binary, implementer's choice).
- IDLE: if FIFO non-empty, pop the head into issue registers; AXI ID = id_cnt; id_cnt += 1 (4-bit, 15 wraps to 0). Go to WADDR if we, else RADDR. Latency: a request pushed into an empty idle block has its AW/AR valid asserted 2 cycles after acceptance.
- WADDR:
  - M_AWVALID and M_WVALID both asserted in the same first cycle; address/data/strobes stable while valid.
  - Each valid drops the cycle after its own handshake (aw_done/w_done flags).
  - When both are done (same or different cycles), go to WRESP.
- WRESP: M_BREADY=1. On M_BVALID: rsp_err = (M_BRESP!=0) | (M_BID!=issued ID); rsp_valid pulse with rsp_rd=0 and rsp_rdata=0; go to IDLE.
- RADDR: M_ARVALID=1 until M_ARREADY, then go to RDATA.
- RDATA: M_RREADY=1. On M_RVALID: capture M_RDATA; rsp_err = (M_RRESP!=0) | (M_RID!=issued ID); rsp_valid pulse with rsp_rd=1; go to IDLE.
- Response outputs are registered; the pulse appears the cycle after the B/R handshake. There is no backpressure on rsp.
- err_flag sets on any rsp_err and clears only on RST.
- Only one transaction outstanding; requests are strictly in order.
- busy = (state!=IDLE) | ~empty.

Optional Feature:
- DEBUG_AXI_MASTER_TIMEOUT_EN defined:
  - A counter starts on entry to WADDR or RADDR and clears in IDLE.
  - If it reaches TIMEOUT_CYC before the B/R handshake: drop all valids/readies, emit rsp_valid with rsp_err=1 (rsp_rdata=0), set err_flag, go to IDLE.
  - A late B/R arriving while IDLE is ignored.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write 0x60000000, data 0x41, strb 0xF, slave AW/W ready 1 cycle after both valid -> AWVALID&WVALID rise together 2 cycles after accept; one rsp_valid with rsp_rd=0, rsp_err=0; BID equals AWID=0.
- Burst of 6 requests with FIFO_DEPTH=4 and slow slave -> req_ready low after 4 buffered; all 6 responses in order; AXI IDs 0..5.
- Read 0x60000000, slave returns RDATA=0xDEADBEEF, RRESP=0 -> rsp_rd=1, rsp_rdata=0xDEADBEEF.
- Slave returns BID mismatched (or BRESP=2'b10) -> rsp_err=1, err_flag stays 1 until RST.
- AWREADY given 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID held; exactly one B accepted.
- 17 writes -> AWID wraps 15 -> 0. Also: RST asserted in WRESP -> all outputs 0 next cycle, no rsp_valid.
